// File: rtl/jmp_ctrl_bp_if.sv
// rtl/jmp_ctrl_bp_if.sv - fetch lookup, resolve and redirect signal bundle for jmp_ctrl_bp
interface jmp_ctrl_bp_if #(
  parameter int XLEN      = 32,
  parameter int STAT_BITS = 16
);
  logic                 ena;
  logic                 f_valid;
  logic [XLEN-1:0]      f_pc;
  logic [XLEN-1:0]      f_imm;
  logic                 f_is_branch;
  logic                 p_valid;
  logic                 p_taken;
  logic [XLEN-1:0]      p_target;
  logic                 r_valid;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_imm;
  logic [XLEN-1:0]      r_rs1;
  logic [2:0]           r_funct3;
  logic                 r_is_branch;
  logic                 r_is_jalr;
  logic                 r_pred_taken;
  logic                 alu_z;
  logic                 alu_n;
  logic                 pc_wr;
  logic [XLEN-1:0]      pc_out;
  logic                 branch_taken;
  logic                 mispredict;
  logic [STAT_BITS-1:0] stat_branches;
  logic [STAT_BITS-1:0] stat_mispredicts;

  modport master (
    output ena, f_valid, f_pc, f_imm, f_is_branch,
           r_valid, r_pc, r_imm, r_rs1, r_funct3, r_is_branch, r_is_jalr, r_pred_taken,
           alu_z, alu_n,
    input  p_valid, p_taken, p_target, pc_wr, pc_out, branch_taken, mispredict,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  ena, f_valid, f_pc, f_imm, f_is_branch,
           r_valid, r_pc, r_imm, r_rs1, r_funct3, r_is_branch, r_is_jalr, r_pred_taken,
           alu_z, alu_n,
    output p_valid, p_taken, p_target, pc_wr, pc_out, branch_taken, mispredict,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/jmp_ctrl_bp.sv
// rtl/jmp_ctrl_bp.sv - branch/JALR resolution with bimodal saturating-counter predictor
module jmp_ctrl_bp #(
  parameter int XLEN         = 32,
  parameter int BHT_IDX_BITS = 6,
  parameter int CTR_BITS     = 2,
  parameter int CTR_INIT     = 1,
  parameter int STAT_BITS    = 16
) (
  input logic          clk,
  input logic          reset,
  jmp_ctrl_bp_if.slave bus
);
  localparam int ENTRIES = 1 << BHT_IDX_BITS;
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic [CTR_BITS-1:0]     bht [ENTRIES];
  logic                    p_valid_q, p_taken_q, pc_wr_q, branch_taken_q, mispredict_q;
  logic [XLEN-1:0]         p_target_q, pc_out_q;
  logic [STAT_BITS-1:0]    stat_br_q, stat_mis_q;

  logic [BHT_IDX_BITS-1:0] f_idx, r_idx;
  logic                    f_go, r_br, r_jalr, cond_taken, br_miss, redirect, lookup_taken;

  assign f_idx        = bus.f_pc[BHT_IDX_BITS+1:2];
  assign r_idx        = bus.r_pc[BHT_IDX_BITS+1:2];
  assign f_go         = bus.f_valid & bus.ena;
  assign r_br         = bus.r_valid & bus.ena & bus.r_is_branch;
  assign r_jalr       = bus.r_valid & bus.ena & bus.r_is_jalr & ~bus.r_is_branch;
  assign lookup_taken = bus.f_is_branch & bht[f_idx][CTR_BITS-1];
  assign br_miss      = r_br & (cond_taken != bus.r_pred_taken);
  assign redirect     = br_miss | r_jalr;

  always_comb begin
    cond_taken = 1'b0;
    case (bus.r_funct3)
      3'b000:          cond_taken = bus.alu_z;
      3'b001:          cond_taken = ~bus.alu_z;
      3'b100, 3'b110:  cond_taken = bus.alu_n;
      3'b101, 3'b111:  cond_taken = ~bus.alu_n;
      default:         cond_taken = 1'b0;
    endcase
  end

  // The table read for the lookup uses the pre-edge value, so a same-cycle update is not seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_BITS'(CTR_INIT);
      p_valid_q      <= 1'b0;
      p_taken_q      <= 1'b0;
      p_target_q     <= '0;
      pc_wr_q        <= 1'b0;
      pc_out_q       <= '0;
      branch_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      stat_br_q      <= '0;
      stat_mis_q     <= '0;
    end else begin
      p_valid_q    <= f_go & ~redirect;
      pc_wr_q      <= redirect;
      mispredict_q <= br_miss;
      if (f_go) begin
        p_taken_q  <= lookup_taken;
        p_target_q <= lookup_taken ? bus.f_pc + bus.f_imm : bus.f_pc + XLEN'(4);
      end
      if (r_br) begin
        if (cond_taken && bht[r_idx] != CTR_MAX)
          bht[r_idx] <= bht[r_idx] + CTR_BITS'(1);
        else if (!cond_taken && bht[r_idx] != '0)
          bht[r_idx] <= bht[r_idx] - CTR_BITS'(1);
        branch_taken_q <= cond_taken;
        if (stat_br_q != STAT_MAX) stat_br_q <= stat_br_q + STAT_BITS'(1);
        if (br_miss) begin
          if (stat_mis_q != STAT_MAX) stat_mis_q <= stat_mis_q + STAT_BITS'(1);
          pc_out_q <= cond_taken ? bus.r_pc + bus.r_imm : bus.r_pc + XLEN'(4);
        end
      end else if (r_jalr) begin
        branch_taken_q <= 1'b1;
        pc_out_q       <= (bus.r_rs1 + bus.r_imm) & ~XLEN'(1);
      end
    end
  end

  assign bus.p_valid          = p_valid_q;
  assign bus.p_taken          = p_taken_q;
  assign bus.p_target         = p_target_q;
  assign bus.pc_wr            = pc_wr_q;
  assign bus.pc_out           = pc_out_q;
  assign bus.branch_taken     = branch_taken_q;
  assign bus.mispredict       = mispredict_q;
  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mis_q;
endmodule

// File: tb/tb_jmp_ctrl_bp.sv
// tb/tb_jmp_ctrl_bp.sv - directed and randomized check of jmp_ctrl_bp against a behavioural model
module tb_jmp_ctrl_bp;
  localparam int XLEN = 32;
  localparam int IDXB = 6;
  localparam int CTRB = 2;
  localparam int CINIT = 1;
  localparam int SB = 4;
  localparam int CMAX = (1 << CTRB) - 1;
  localparam int SMAX = (1 << SB) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jmp_ctrl_bp_if #(.XLEN(XLEN), .STAT_BITS(SB)) bus ();
  jmp_ctrl_bp #(.XLEN(XLEN), .BHT_IDX_BITS(IDXB), .CTR_BITS(CTRB), .CTR_INIT(CINIT),
                .STAT_BITS(SB)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass = 0;

  int m_ctr [1 << IDXB];
  bit m_pvalid, m_ptaken, m_pcwr, m_bt, m_mis;
  logic [XLEN-1:0] m_ptarget, m_pcout;
  int m_sb, m_sm;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  function automatic bit branch_cond(input logic [2:0] f3, input bit z, input bit n);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4, 3'd6: return n;
      3'd5, 3'd7: return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    bus.f_valid = 0; bus.r_valid = 0; bus.r_is_branch = 0; bus.r_is_jalr = 0;
  endtask

  // Advance one clock: model the edge from the current inputs, then compare every output.
  task automatic step();
    bit fgo, br, jalr, tk, miss;
    int fi, ri;
    if (reset) begin
      foreach (m_ctr[i]) m_ctr[i] = CINIT;
      m_pvalid = 0; m_ptaken = 0; m_ptarget = 0; m_pcwr = 0; m_pcout = 0;
      m_bt = 0; m_mis = 0; m_sb = 0; m_sm = 0;
    end else begin
      fgo  = bus.f_valid && bus.ena;
      br   = bus.r_valid && bus.ena && bus.r_is_branch;
      jalr = bus.r_valid && bus.ena && bus.r_is_jalr && !bus.r_is_branch;
      tk   = branch_cond(bus.r_funct3, bus.alu_z, bus.alu_n);
      miss = br && (tk != bus.r_pred_taken);
      fi   = int'((bus.f_pc >> 2) % (1 << IDXB));
      ri   = int'((bus.r_pc >> 2) % (1 << IDXB));
      m_pvalid = fgo && !(miss || jalr);
      if (fgo) begin
        m_ptaken  = bus.f_is_branch && (m_ctr[fi] >= (1 << (CTRB - 1)));
        m_ptarget = m_ptaken ? bus.f_pc + bus.f_imm : bus.f_pc + 4;
      end
      m_pcwr = miss || jalr;
      m_mis  = miss;
      if (br) begin
        m_ctr[ri] = tk ? ((m_ctr[ri] + 1 > CMAX) ? CMAX : m_ctr[ri] + 1)
                       : ((m_ctr[ri] - 1 < 0) ? 0 : m_ctr[ri] - 1);
        m_bt = tk;
        m_sb = (m_sb + 1 > SMAX) ? SMAX : m_sb + 1;
        if (miss) begin
          m_sm = (m_sm + 1 > SMAX) ? SMAX : m_sm + 1;
          m_pcout = tk ? bus.r_pc + bus.r_imm : bus.r_pc + 4;
        end
      end else if (jalr) begin
        m_bt = 1;
        m_pcout = (bus.r_rs1 + bus.r_imm) & ~32'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("p_valid", bus.p_valid, m_pvalid);
    chk("p_taken", bus.p_taken, m_ptaken);
    chk("p_target", bus.p_target, m_ptarget);
    chk("pc_wr", bus.pc_wr, m_pcwr);
    chk("pc_out", bus.pc_out, m_pcout);
    chk("branch_taken", bus.branch_taken, m_bt);
    chk("mispredict", bus.mispredict, m_mis);
    chk("stat_branches", bus.stat_branches, m_sb);
    chk("stat_mispredicts", bus.stat_mispredicts, m_sm);
  endtask

  task automatic lookup(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
    idle(); bus.f_valid = 1; bus.f_pc = pc; bus.f_imm = imm; bus.f_is_branch = 1;
  endtask

  task automatic resolve_br(input logic [XLEN-1:0] pc, input logic [2:0] f3, input bit z,
                            input bit n, input bit pred);
    idle(); bus.r_valid = 1; bus.r_is_branch = 1; bus.r_pc = pc; bus.r_imm = 32'h40;
    bus.r_funct3 = f3; bus.alu_z = z; bus.alu_n = n; bus.r_pred_taken = pred;
  endtask

  initial begin
    reset = 1; bus.ena = 1; idle();
    bus.f_pc = 0; bus.f_imm = 0; bus.f_is_branch = 0; bus.r_pc = 0; bus.r_imm = 0;
    bus.r_rs1 = 0; bus.r_funct3 = 0; bus.r_pred_taken = 0; bus.alu_z = 0; bus.alu_n = 0;
    step();
    chk("reset_p_valid", bus.p_valid, 0);
    chk("reset_pc_out", bus.pc_out, 0);
    reset = 0;

    lookup(32'h100, 32'h40); step();
    chk("cold_p_valid", bus.p_valid, 1);
    chk("cold_p_taken", bus.p_taken, 0);
    chk("cold_p_target", bus.p_target, 32'h104);

    resolve_br(32'h100, 3'd0, 1, 0, 0); step();
    chk("beq_pc_wr", bus.pc_wr, 1);
    chk("beq_pc_out", bus.pc_out, 32'h140);
    chk("beq_mispredict", bus.mispredict, 1);
    step();
    lookup(32'h100, 32'h40); step();
    chk("trained_p_taken", bus.p_taken, 1);
    chk("trained_p_target", bus.p_target, 32'h140);

    repeat (5) begin resolve_br(32'h204, 3'd0, 1, 0, 1); step(); end
    resolve_br(32'h204, 3'd0, 0, 0, 1); step();
    lookup(32'h204, 32'h40); step();
    chk("sat_still_taken", bus.p_taken, 1);
    repeat (3) begin resolve_br(32'h204, 3'd0, 0, 0, 0); step(); end
    lookup(32'h204, 32'h40); step();
    chk("sat_now_not_taken", bus.p_taken, 0);

    idle(); bus.r_valid = 1; bus.r_is_jalr = 1; bus.r_rs1 = 32'h2001; bus.r_imm = 32'h10;
    step();
    chk("jalr_pc_wr", bus.pc_wr, 1);
    chk("jalr_pc_out", bus.pc_out, 32'h2010);
    chk("jalr_mispredict", bus.mispredict, 0);

    resolve_br(32'h300, 3'd5, 0, 0, 1); step();
    chk("bge_correct_pc_wr", bus.pc_wr, 0);

    resolve_br(32'h208, 3'd0, 1, 0, 0);
    bus.f_valid = 1; bus.f_pc = 32'h208; bus.f_imm = 32'h80; bus.f_is_branch = 1;
    step();
    chk("same_cycle_old_ctr", bus.p_taken, 0);
    chk("same_cycle_flush", bus.p_valid, 0);
    lookup(32'h208, 32'h80); step();
    chk("after_update_taken", bus.p_taken, 1);

    resolve_br(32'h20c, 3'd0, 1, 0, 0); bus.ena = 0; step();
    chk("ena0_pc_wr", bus.pc_wr, 0);
    bus.ena = 1;

    repeat (20) begin resolve_br(32'h400, 3'd1, 0, 0, 0); step(); end
    chk("stat_mis_saturated", bus.stat_mispredicts, 15);

    resolve_br(32'h100, 3'd0, 0, 0, 1); reset = 1; step();
    chk("midreset_pc_wr", bus.pc_wr, 0);
    chk("midreset_stat", bus.stat_branches, 0);
    reset = 0;
    lookup(32'h100, 32'h40); step();
    chk("midreset_ctr_init", bus.p_taken, 0);

    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      bus.ena = ($urandom_range(0, 7) != 0);
      bus.f_valid = $urandom_range(0, 1);
      bus.f_pc = {$urandom_range(0, 3) == 0 ? $urandom() : 32'h0} | ($urandom_range(0, 127) << 2);
      bus.f_imm = $urandom();
      bus.f_is_branch = $urandom_range(0, 3) != 0;
      bus.r_valid = $urandom_range(0, 1);
      bus.r_is_branch = $urandom_range(0, 3) != 0;
      bus.r_is_jalr = !bus.r_is_branch && $urandom_range(0, 1);
      bus.r_pc = $urandom_range(0, 127) << 2;
      bus.r_imm = $urandom();
      bus.r_rs1 = $urandom();
      bus.r_funct3 = 3'($urandom_range(0, 7));
      bus.r_pred_taken = $urandom_range(0, 1);
      bus.alu_z = $urandom_range(0, 1);
      bus.alu_n = $urandom_range(0, 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
